// File: rtl/env_mem_arbiter_pkg.sv
// Shared parameters and types for the environment RAM arbiter.
package env_mem_arbiter_pkg;

  localparam int X_bits      = 5;
  localparam int Y_bits      = 5;
  localparam int ARB_MAX_ENG = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/env_mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  int          j;
  logic [IW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    k   = '0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      k = j[IW-1:0];
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/env_mem_arbiter.sv
// Env RAM arbiter: display has absolute priority, engines round-robin with burst lock; grant is combinational, rvalid one cycle later.
// Ineligible requesters simply wait ungranted; defining ENV_ARB_STATS_EN adds stat_grants/stat_max_wait counters.
module env_mem_arbiter
  import env_mem_arbiter_pkg::*;
#(
  parameter int N_ENG     = 4,
  parameter int MAX_BURST = 8,
  parameter int ADDR_W    = X_bits + Y_bits,
  parameter int DATA_W    = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       write_flag,
  input  logic                       disp_req,
  input  logic [ADDR_W-1:0]          disp_addr,
  output logic                       disp_gnt,
  input  logic [N_ENG-1:0]           eng_req,
  input  logic [N_ENG-1:0]           eng_lock,
  input  logic [N_ENG-1:0]           eng_we,
  input  logic [N_ENG*ADDR_W-1:0]    eng_addr,
  input  logic [N_ENG*DATA_W-1:0]    eng_wdata,
  output logic [N_ENG-1:0]           eng_gnt,
  output logic [N_ENG:0]             rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata
`ifdef ENV_ARB_STATS_EN
  ,
  output logic [N_ENG*32-1:0]        stat_grants,
  output logic [15:0]                stat_max_wait
`endif
);

  localparam int IW = idx_w(N_ENG);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     beng_q, beng_d;
  logic [N_ENG:0]    rvalid_q, rvalid_d;

  logic [N_ENG-1:0]  elig;
  logic [N_ENG-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic              resume;
  logic [N_ENG-1:0]  gnt_raw;
  logic              disp_raw;
  logic [IW-1:0]     sel;
  logic [CW-1:0]     cnt_inc;

  assign elig = eng_req & ~(eng_we & {N_ENG{~write_flag}});

  rr_pick #(.N(N_ENG), .IW(IW)) u_rr_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // A non-zero counter marks a live burst, including one suspended by a display cycle.
  assign resume  = (state_q != IDLE) && (cnt_q != '0) && elig[beng_q] && eng_lock[beng_q];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = IDLE;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    beng_d   = beng_q;
    gnt_raw  = '0;
    disp_raw = 1'b0;
    sel      = '0;
    if (disp_req) begin
      disp_raw = 1'b1;
      state_d  = SERVE;
    end else if (resume) begin
      sel          = beng_q;
      gnt_raw[sel] = 1'b1;
      ptr_d        = (sel == IW'(N_ENG - 1)) ? '0 : sel + 1'b1;
      if (cnt_inc == MAX_C) begin
        cnt_d   = '0;
        state_d = SERVE;
      end else begin
        cnt_d   = cnt_inc;
        state_d = BURST;
      end
    end else if (pick_vld) begin
      sel     = pick_idx;
      gnt_raw = pick_gnt;
      ptr_d   = (sel == IW'(N_ENG - 1)) ? '0 : sel + 1'b1;
      if (eng_lock[sel] && (MAX_BURST > 1)) begin
        cnt_d   = CW'(1);
        beng_d  = sel;
        state_d = BURST;
      end else begin
        cnt_d   = '0;
        state_d = SERVE;
      end
    end else begin
      cnt_d   = '0;
      state_d = IDLE;
    end
    rvalid_d = {gnt_raw & ~eng_we, disp_raw};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      beng_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      beng_q   <= beng_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Grants are combinational, so reset gates them directly to keep strobes low at once.
  assign disp_gnt  = disp_raw & Reset_n;
  assign eng_gnt   = gnt_raw & {N_ENG{Reset_n}};
  assign ram_en    = Reset_n & (disp_raw | (|gnt_raw));
  assign ram_we    = Reset_n & ~disp_raw & (|gnt_raw) & eng_we[sel];
  assign ram_addr  = disp_raw ? disp_addr : eng_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign ram_wdata = eng_wdata[int'(sel)*DATA_W +: DATA_W];
  assign rvalid    = rvalid_q;
  assign rdata     = (|rvalid_q) ? ram_rdata : '0;

`ifdef ENV_ARB_STATS_EN
  logic [N_ENG-1:0][31:0] sg_q, sg_d;
  logic [N_ENG-1:0][15:0] wt_q, wt_d;
  logic [15:0]            mx_q, mx_d;

  always_comb begin
    mx_d = mx_q;
    sg_d = sg_q;
    wt_d = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (eng_gnt[i] && (sg_q[i] != '1)) sg_d[i] = sg_q[i] + 32'd1;
      if (elig[i] && !eng_gnt[i]) wt_d[i] = (wt_q[i] == '1) ? wt_q[i] : wt_q[i] + 16'd1;
      if (wt_d[i] > mx_d) mx_d = wt_d[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sg_q <= '0;
      wt_q <= '0;
      mx_q <= '0;
    end else begin
      sg_q <= sg_d;
      wt_q <= wt_d;
      mx_q <= mx_d;
    end
  end

  assign stat_grants   = sg_q;
  assign stat_max_wait = mx_q;
`endif

endmodule

// File: tb/tb_env_mem_arbiter.sv
// Self-checking bench for env_mem_arbiter with a RAM model and an rvalid scoreboard.
module tb_env_mem_arbiter;
  import env_mem_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = X_bits + Y_bits;
  localparam int DW = 8;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            write_flag, disp_req;
  logic [AW-1:0]   disp_addr;
  logic            disp_gnt;
  logic [N-1:0]    eng_req, eng_lock, eng_we, eng_gnt;
  logic [N*AW-1:0] eng_addr;
  logic [N*DW-1:0] eng_wdata;
  logic [N:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N:0]    v;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 Clk = ~Clk;

  env_mem_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n), .write_flag(write_flag),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .eng_req(eng_req), .eng_lock(eng_lock), .eng_we(eng_we),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_gnt(eng_gnt),
    .rvalid(rvalid), .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 7 + 3);
  endfunction

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = init_val(a);
    ram_rdata = '0;
  end

  always @(posedge Clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // A reset drops every outstanding read.
  always @(negedge Reset_n) sb.delete();

  always @(negedge Clk) begin
    exp_t e;
    exp_t n;
    e.v = '0;
    e.d = '0;
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (rvalid !== e.v || ((e.v != '0) && rdata !== e.d) || ((e.v == '0) && rdata !== '0)) begin
      errors++;
      $display("FAIL sb_rvalid t=%0t: rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
               $time, rvalid, rdata, e.v, e.d);
    end
    checks++;
    if ((disp_gnt && eng_gnt != '0) || !$onehot0(eng_gnt)) begin
      errors++;
      $display("FAIL gnt_exclusive t=%0t: disp_gnt=%b eng_gnt=%b", $time, disp_gnt, eng_gnt);
    end
    n.v = '0;
    n.d = '0;
    if (ram_en && !ram_we) begin
      n.v = {eng_gnt, disp_gnt};
      n.d = mem[ram_addr];
    end
    sb.push_back(n);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    disp_req   = 1'b0;
    disp_addr  = AW'(10'h2F0);
    write_flag = 1'b0;
    eng_req    = '0;
    eng_lock   = '0;
    eng_we     = '0;
    for (int i = 0; i < N; i++) begin
      eng_addr[i*AW +: AW]  = AW'(256 + i * 17);
      eng_wdata[i*DW +: DW] = DW'(160 + i);
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(posedge Clk); #1 Reset_n = 1'b0;
    @(posedge Clk); #1 Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge Clk); #1;
    disp_req   = 1'b1;
    eng_req    = '1;
    write_flag = 1'b1;
    @(negedge Clk);
    checks++;
    if ({disp_gnt, eng_gnt, ram_en, ram_we} !== '0) begin
      errors++;
      $display("FAIL reset_strobes: disp_gnt=%b eng_gnt=%b ram_en=%b ram_we=%b, required all 0",
               disp_gnt, eng_gnt, ram_en, ram_we);
    end
    checks++;
    if (rvalid !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_rvalid: rvalid=%b rdata=%h, required 0", rvalid, rdata);
    end
    idle_inputs();
    @(posedge Clk); #1 Reset_n = 1'b1;
  endtask

  task automatic test_contention();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    eng_req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      checks++;
      if (eng_gnt !== (4'b0001 << exp_seq[c])) begin
        errors++;
        $display("FAIL contention c=%0d: eng_gnt=%b, required engine %0d", c, eng_gnt, exp_seq[c]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_preempt();
    int exp_p[10] = '{2, 2, 2, -1, 2, 2, 2, 2, 2, 3};
    int n2 = 0;
    bit seen3 = 1'b0;
    apply_reset();
    eng_req  = 4'b1100;
    eng_lock = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(posedge Clk); #1;
      end
      disp_req = (c == 3);
      @(negedge Clk);
      checks++;
      if (exp_p[c] < 0) begin
        if (disp_gnt !== 1'b1 || eng_gnt !== '0 || ram_addr !== disp_addr) begin
          errors++;
          $display("FAIL preempt_disp: disp_gnt=%b eng_gnt=%b ram_addr=%h, required 1/0000/%h",
                   disp_gnt, eng_gnt, ram_addr, disp_addr);
        end
      end else if (disp_gnt !== 1'b0 || eng_gnt !== (4'b0001 << exp_p[c])) begin
        errors++;
        $display("FAIL preempt_seq c=%0d: disp_gnt=%b eng_gnt=%b, required engine %0d",
                 c, disp_gnt, eng_gnt, exp_p[c]);
      end
      if (eng_gnt[3]) seen3 = 1'b1;
      if (eng_gnt == 4'b0100 && !seen3) n2++;
    end
    checks++;
    if (n2 !== 8) begin
      errors++;
      $display("FAIL preempt_total: engine-2 burst grants=%0d, required 8", n2);
    end
    idle_inputs();
  endtask

  task automatic test_write_gate();
    apply_reset();
    eng_req                = 4'b0010;
    eng_we                 = 4'b0010;
    eng_wdata[1*DW +: DW]  = 8'h5C;
    eng_addr[1*AW +: AW]   = AW'(10'h033);
    eng_addr[0 +: AW]      = AW'(10'h033);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      checks++;
      if (eng_gnt !== '0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL wgate_hold c=%0d: eng_gnt=%b ram_en=%b, required 0000/0", c, eng_gnt, ram_en);
      end
    end
    @(posedge Clk); #1 write_flag = 1'b1;
    @(negedge Clk);
    checks++;
    if (eng_gnt !== 4'b0010 || ram_we !== 1'b1 || ram_en !== 1'b1) begin
      errors++;
      $display("FAIL wgate_grant: eng_gnt=%b ram_en=%b ram_we=%b, required 0010/1/1", eng_gnt, ram_en, ram_we);
    end
    checks++;
    if (ram_addr !== AW'(10'h033) || ram_wdata !== 8'h5C) begin
      errors++;
      $display("FAIL wgate_data: ram_addr=%h ram_wdata=%h, required 033/5c", ram_addr, ram_wdata);
    end
    @(posedge Clk); #1 eng_lock = 4'b0010;
    @(negedge Clk);
    checks++;
    if (eng_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wgate_lock: eng_gnt=%b, required 0010", eng_gnt);
    end
    @(posedge Clk); #1;
    write_flag = 1'b0;
    eng_req    = 4'b0011;
    @(negedge Clk);
    checks++;
    if (eng_gnt !== 4'b0001 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL wgate_fall: eng_gnt=%b ram_we=%b, required 0001/0", eng_gnt, ram_we);
    end
    @(posedge Clk); #1 eng_req = 4'b0000;
    @(negedge Clk);
    checks++;
    if (rvalid !== 5'b00010 || rdata !== 8'h5C) begin
      errors++;
      $display("FAIL wgate_readback: rvalid=%b rdata=%h, required 00010/5c", rvalid, rdata);
    end
    idle_inputs();
  endtask

  task automatic test_burst_cap();
    apply_reset();
    eng_req  = 4'b0011;
    eng_lock = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      @(negedge Clk);
      checks++;
      if (eng_gnt !== ((c < 8) ? 4'b0001 : 4'b0010)) begin
        errors++;
        $display("FAIL burst_cap c=%0d: eng_gnt=%b, required engine %0d", c, eng_gnt, (c < 8) ? 0 : 1);
      end
    end
    idle_inputs();
  endtask

  task automatic test_read_latency();
    apply_reset();
    eng_req              = 4'b1000;
    eng_addr[3*AW +: AW] = AW'(10'h1A5);
    @(negedge Clk);
    checks++;
    if (eng_gnt !== 4'b1000 || ram_addr !== AW'(10'h1A5) || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rlat_grant: eng_gnt=%b ram_addr=%h ram_we=%b, required 1000/1a5/0", eng_gnt, ram_addr, ram_we);
    end
    @(posedge Clk); #1 eng_req = '0;
    @(negedge Clk);
    checks++;
    if (rvalid !== 5'b10000 || rdata !== init_val(421)) begin
      errors++;
      $display("FAIL rlat_data: rvalid=%b rdata=%h, required 10000/%h", rvalid, rdata, init_val(421));
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (rvalid !== '0) begin
      errors++;
      $display("FAIL rlat_single: rvalid=%b, required 00000", rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    eng_req = 4'b0001;
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (rvalid !== 5'b00010) begin
      errors++;
      $display("FAIL rmid_pre: rvalid=%b, required 00010", rvalid);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({disp_gnt, eng_gnt, ram_en, ram_we, rvalid, rdata} !== '0) begin
      errors++;
      $display("FAIL rmid_outputs: gnt=%b/%b en=%b we=%b rvalid=%b rdata=%h, required all 0",
               disp_gnt, eng_gnt, ram_en, ram_we, rvalid, rdata);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    eng_req = '0;
    @(negedge Clk);
    checks++;
    if (rvalid !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL rmid_after: rvalid=%b rdata=%h, required 0", rvalid, rdata);
    end
    idle_inputs();
  endtask

  initial begin
    Reset_n = 1'b1;
    idle_inputs();
    #2 Reset_n = 1'b0;
    test_reset();
    test_contention();
    test_preempt();
    test_write_gate();
    test_burst_cap();
    test_read_latency();
    test_reset_mid_read();
    repeat (2) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/env_mem_arbiter.md
ENV_MEM_ARBITER -- requirements
Module: env_mem_arbiter

Interface
REQ-001 SHALL have parameter N_ENG, default 4: number of ant-engine requesters, range 1..7.
REQ-002 SHALL have parameter MAX_BURST, default 8: maximum consecutive grants to one engine holding lock.
REQ-003 SHALL have parameter ADDR_W, default X_bits+Y_bits: environment RAM address width.
REQ-004 SHALL have parameter DATA_W, default 8: environment cell width.
REQ-005 SHALL have ports:
- Clk  in  1  single clock.
- Reset_n  in  1  asynchronous, active-low reset.
- write_flag  in  1  sim-state write window; engine writes are legal only while high.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display granted this cycle.
- eng_req  in  N_ENG  per-engine request.
- eng_lock  in  N_ENG  per-engine burst-lock hint.
- eng_we  in  N_ENG  per-engine write enable.
- eng_addr  in  N_ENG*ADDR_W  packed addresses.
- eng_wdata  in  N_ENG*DATA_W  packed write data.
- eng_gnt  out  N_ENG  one-hot engine grant.
- rvalid  out  N_ENG+1  read data valid; bit 0 is display, bits 1..N_ENG are engines.
- rdata  out  DATA_W  read data shared by all requesters.
- ram_en, ram_we  out  1  RAM strobes.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency.

Function
REQ-006 SHALL issue at most one RAM access per cycle; the granted requester's address/data SHALL drive the RAM combinationally in the grant cycle.
REQ-007 Display SHALL have absolute priority: disp_req=1 gives disp_gnt=1 the same cycle and preempts any engine, including one in a burst.
REQ-008 An engine is eligible iff eng_req[i]=1 and (eng_we[i]=0 or write_flag=1); an ineligible write request SHALL wait, not be dropped.
REQ-009 Among eligible engines, grant SHALL be round-robin starting at the index after the last granted engine; pointer resets to engine 0.
REQ-010 FSM states SHALL be IDLE, SERVE, BURST.
- IDLE to SERVE: any grant issued.
- SERVE to BURST: granted engine has eng_lock=1.
- BURST: same engine keeps grant while eng_req and eng_lock are high and eligible; burst counter increments per grant.
- BURST to SERVE: counter reaches MAX_BURST, lock drops, or display preempts; round-robin pointer advances.
- Any state to IDLE: no grant that cycle.
REQ-011 A display preemption in BURST SHALL not reset the burst counter; the burst resumes on the next cycle if the lock is still held.
REQ-012 For a read grant, rvalid[k] SHALL pulse exactly one cycle later with rdata=ram_rdata; write grants produce no rvalid.
REQ-013 If write_flag falls during BURST, pending writes SHALL lose eligibility next cycle; reads continue.
REQ-014 eng_gnt SHALL always be one-hot or zero, and SHALL never be asserted in the same cycle as disp_gnt.

Reset
REQ-015 Reset_n=0 SHALL asynchronously force: state IDLE, RR pointer 0, burst counter 0, and all gnt, rvalid, ram_en and ram_we outputs 0; rdata 0.
REQ-016 A reset mid-access SHALL discard the pending rvalid; no requester state is retained.

Configuration
REQ-017 Macro ENV_ARB_STATS_EN, when defined, SHALL add outputs stat_grants (32-bit, per-engine packed, saturating) and stat_max_wait (16-bit, longest cycles any eligible engine waited), both cleared by reset; when undefined, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-018 The state enum arb_state_t and the constant ARB_MAX_ENG=7 SHALL live in the shared params package alongside X_bits/Y_bits.
REQ-019 Round-robin selection SHALL be a sub-module rr_pick (request vector plus pointer in, one-hot grant plus index out, purely combinational).

Verification
REQ-020 Reset: Reset_n low mid-read -> all outputs 0 within the cycle, no rvalid afterwards.
REQ-021 Contention: eng_req=4'b1111 held, no display -> grants go 0,1,2,3,0 on consecutive cycles.
REQ-022 Display preemption: engine 2 in BURST, disp_req pulsed for 1 cycle -> disp_gnt=1 and eng_gnt=0 that cycle, engine 2 resumes next cycle, total engine-2 grants=8.
REQ-023 Write gating: eng_we[1]=1 with write_flag=0 for 5 cycles -> no grant; write_flag rises -> grant the same cycle, ram_we=1.
REQ-024 Burst cap: engine 0 locked with MAX_BURST=8 and engine 1 requesting -> engine 0 granted for 8 cycles, then engine 1 granted.
REQ-025 Read latency: engine 3 reads address 0x1A5 -> rvalid[4]=1 exactly one cycle later with rdata equal to the RAM contents.
